// File: rtl/uart_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_program_loader
// Brief    : Loads N 16-bit words (low byte first) from a UART receive FIFO
//            into program memory. Define LOADER_ECHO_EN to echo every byte.
// Revision : 1.0  initial release
// ============================================================================
module uart_program_loader #(
    parameter int          ADDR_W      = 8,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CNT = 3'd1,
        GET_LO  = 3'd2,
        GET_HI  = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
`ifdef LOADER_ECHO_EN
        ,
        ECHO    = 3'd7
`endif
    } state_t;

    state_t              state_q;
    state_t              nxt_d;
    logic [7:0]          rem_q;
    logic [7:0]          lo_q;
    logic [7:0]          hi_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic [23:0]         tmo_q;
    logic [23:0]         tmo_d;
    logic                rd_uart_q;
    logic                mem_we_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                take_d;
    logic                wait_d;

`ifdef LOADER_ECHO_EN
    state_t              ret_q;
    logic [7:0]          echo_q;
    logic [7:0]          w_data_q;
    logic                wr_uart_q;
`endif

    // The FIFO head is stale while a pop is in flight, so the cycle after
    // rd_uart neither consumes a byte nor advances the timeout.
    always_comb begin
        take_d = 1'b0;
        wait_d = 1'b0;
        tmo_d  = tmo_q + 24'd1;
        nxt_d  = IDLE;
        if (!rd_uart_q && (state_q == GET_CNT || state_q == GET_LO || state_q == GET_HI)) begin
            take_d = !rx_empty;
            wait_d = rx_empty;
        end
        case (state_q)
            GET_CNT: nxt_d = (r_data == 8'd0) ? DONE : GET_LO;
            GET_LO:  nxt_d = GET_HI;
            GET_HI:  nxt_d = WRITE;
            default: nxt_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= 8'd0;
            lo_q        <= 8'd0;
            hi_q        <= 8'd0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'd0;
            tmo_q       <= 24'd0;
            rd_uart_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_ECHO_EN
            ret_q       <= IDLE;
            echo_q      <= 8'd0;
            w_data_q    <= 8'd0;
            wr_uart_q   <= 1'b0;
`endif
        end else begin
            rd_uart_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOADER_ECHO_EN
            wr_uart_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= GET_CNT;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                        tmo_q   <= 24'd0;
                    end
                end
                GET_CNT, GET_LO, GET_HI: begin
                    if (take_d) begin
                        rd_uart_q <= 1'b1;
                        tmo_q     <= 24'd0;
                        if (state_q == GET_CNT) begin
                            rem_q  <= r_data;
                            addr_q <= '0;
                        end
                        if (state_q == GET_LO) lo_q <= r_data;
                        if (state_q == GET_HI) hi_q <= r_data;
`ifdef LOADER_ECHO_EN
                        echo_q  <= r_data;
                        ret_q   <= nxt_d;
                        state_q <= ECHO;
`else
                        state_q <= nxt_d;
`endif
                    end else if (wait_d) begin
                        if (tmo_d >= TIMEOUT_CYC) state_q <= ERROR;
                        else                      tmo_q   <= tmo_d;
                    end
                end
                WRITE: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= addr_q;
                    mem_wdata_q <= {hi_q, lo_q};
                    addr_q      <= addr_q + ADDR_W'(1);
                    rem_q       <= rem_q - 8'd1;
                    state_q     <= (rem_q == 8'd1) ? DONE : GET_LO;
                end
`ifdef LOADER_ECHO_EN
                ECHO: begin
                    if (!tx_full) begin
                        wr_uart_q <= 1'b1;
                        w_data_q  <= echo_q;
                        state_q   <= ret_q;
                    end
                end
`endif
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERROR: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_uart   = rd_uart_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

`ifdef LOADER_ECHO_EN
    assign wr_uart = wr_uart_q;
    assign w_data  = w_data_q;
`else
    logic unused_tx_full;
    assign unused_tx_full = tx_full;
    assign wr_uart = 1'b0;
    assign w_data  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_program_loader
// Brief    : Scoreboard bench: a FIFO model feeds bytes, a reference model
//            predicts memory writes / done / error, a monitor compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_program_loader;

    localparam int          ADDR_W = 3;
    localparam logic [23:0] TMO    = 24'd60;
`ifdef LOADER_ECHO_EN
    localparam int          WE_LAT = 2;
`else
    localparam int          WE_LAT = 1;
`endif

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic              rx_empty = 1'b1;
    logic [7:0]        r_data   = 8'd0;
    logic              tx_full  = 1'b0;
    logic              rd_uart;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;

    uart_program_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_empty(rx_empty),
        .r_data(r_data), .rd_uart(rd_uart), .tx_full(tx_full), .w_data(w_data),
        .wr_uart(wr_uart), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // kind: 0 = memory write, 1 = done pulse, 2 = error rising
    typedef struct { int kind; int addr; int data; } ev_t;

    ev_t        expq[$];
    logic [7:0] rxq[$];
    logic [7:0] echoq[$];
    int         checks    = 0;
    int         errors    = 0;
    int         pop_count = 0;
    int         wr_seen   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receive FIFO model: pops on the edge where rd_uart was high.
    logic fifo_popped;
    always @(posedge clk) begin
        fifo_popped = rd_uart;
        #1;
        if (fifo_popped) begin
            checks++;
            if (rxq.size() == 0) begin
                errors++;
                $display("FAIL pop_from_empty: got rd_uart=1 expected no pop");
            end else begin
`ifdef LOADER_ECHO_EN
                echoq.push_back(rxq[0]);
`endif
                void'(rxq.pop_front());
                pop_count++;
            end
        end
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    end

    // Monitor / scoreboard.
    logic rd_prev  = 1'b0;
    logic err_prev = 1'b0;
    int   cyc      = 0;
    int   last_rd  = 0;
    ev_t  ev;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            rd_prev  = 1'b0;
            err_prev = 1'b0;
        end else begin
            if (rd_uart) check("rd_uart_back_to_back", rd_prev, 1'b0);
            if (mem_we) begin
                if (expq.size() == 0 || expq[0].kind != 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%h expected no write", mem_addr, mem_wdata);
                end else begin
                    ev = expq.pop_front();
                    check("write_addr", 64'(mem_addr), 64'(ev.addr));
                    check("write_data", 64'(mem_wdata), 64'(ev.data));
                    check("we_latency", 64'(cyc - last_rd), 64'(WE_LAT));
                end
            end
            if (done) begin
                if (expq.size() == 0 || expq[0].kind != 1) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected %0s", expq.size() == 0 ? "nothing" : "other event");
                end else begin
                    void'(expq.pop_front());
                    check("done_busy_low", busy, 1'b0);
                end
            end
            if (error && !err_prev) begin
                if (expq.size() == 0 || expq[0].kind != 2) begin
                    checks++; errors++;
                    $display("FAIL unexpected_error: got error=1 expected %0s", expq.size() == 0 ? "nothing" : "other event");
                end else begin
                    void'(expq.pop_front());
                end
            end
            if (wr_uart) begin
                wr_seen++;
`ifdef LOADER_ECHO_EN
                if (echoq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL echo_extra: got w_data=0x%h expected no echo", w_data);
                end else begin
                    check("echo_byte", w_data, echoq.pop_front());
                end
`endif
            end
            if (rd_uart) last_rd = cyc;
            rd_prev  = rd_uart;
            err_prev = error;
        end
    end

    // Reference model: count byte, then complete (lo,hi) pairs become writes
    // at sequential wrapping addresses; a short stream ends in a timeout.
    task automatic model_session(input logic [7:0] bytes[$]);
        int n     = int'(bytes[0]);
        int avail = (bytes.size() - 1) / 2;
        int w     = (avail < n) ? avail : n;
        for (int i = 0; i < w; i++)
            expq.push_back(ev_t'{kind: 0, addr: i % (1 << ADDR_W),
                                 data: int'(bytes[2 + 2*i]) * 256 + int'(bytes[1 + 2*i])});
        expq.push_back(ev_t'{kind: (w == n) ? 1 : 2, addr: 0, data: 0});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("error_cleared_by_start", error, 1'b0);
    endtask

    task automatic send(input logic [7:0] bytes[$], input int maxgap);
        foreach (bytes[i]) begin
            repeat ($urandom_range(0, maxgap)) tick();
            rxq.push_back(bytes[i]);
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        int k = 0;
        while ((expq.size() != 0 || busy) && k < limit) begin
            tick();
            k++;
        end
        if (k >= limit) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d events pending busy=%0b expected completion", name, expq.size(), busy);
        end
        check({name, "_pending"}, 64'(expq.size()), 64'd0);
        check({name, "_busy"}, busy, 1'b0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_uart"},   rd_uart,   1'b0);
        check({name, "_wr_uart"},   wr_uart,   1'b0);
        check({name, "_mem_we"},    mem_we,    1'b0);
        check({name, "_busy"},      busy,      1'b0);
        check({name, "_done"},      done,      1'b0);
        check({name, "_error"},     error,     1'b0);
        check({name, "_mem_addr"},  64'(mem_addr), 64'd0);
        check({name, "_mem_wdata"}, mem_wdata, 16'd0);
        check({name, "_w_data"},    w_data,    8'd0);
    endtask

    task automatic run_session(input logic [7:0] bytes[$], input int maxgap, input string name);
        model_session(bytes);
        pulse_start();
        send(bytes, maxgap);
        wait_done(name, 3000);
    endtask

    task automatic run_random(input int idx);
        logic [7:0] b[$];
        int n = $urandom_range(1, 12);
        b.push_back(8'(n));
        for (int k = 0; k < 2*n; k++) b.push_back(8'($urandom_range(0, 255)));
        run_session(b, $urandom_range(0, 8), $sformatf("random%0d", idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] q[$];
    int         p0;
    int         w0;

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("post_reset");

        q = {8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        run_session(q, 3, "two_words");

        q = {8'h00};
        p0 = pop_count;
        run_session(q, 2, "zero_count");
        check("zero_count_pops", 64'(pop_count - p0), 64'd1);

        for (int s = 0; s < 6; s++) run_random(s);

        // Whole stream queued up front: rx_empty stays low through the session.
        q = {8'd255};
        for (int k = 0; k < 510; k++) q.push_back(8'($urandom_range(0, 255)));
        model_session(q);
        foreach (q[i]) rxq.push_back(q[i]);
        p0 = pop_count;
        repeat (10) tick();
        check("idle_no_pop", 64'(pop_count - p0), 64'd0);
        pulse_start();
        wait_done("continuous", 4000);
        check("continuous_pops", 64'(pop_count - p0), 64'd511);

        q = {8'h03, 8'h11, 8'h22};
        model_session(q);
        pulse_start();
        send(q, 2);
        wait_done("timeout", int'(TMO) + 200);
        check("timeout_error_set", error, 1'b1);
        q = {8'h00};
        run_session(q, 0, "after_timeout");
        check("after_timeout_error", error, 1'b0);

        // Reset while waiting for the high byte of word 1.
        expq.push_back(ev_t'{kind: 0, addr: 0, data: 16'h5678});
        q = {8'h02, 8'h78, 8'h56, 8'h9A};
        p0 = pop_count;
        pulse_start();
        send(q, 1);
        w0 = 0;
        while ((pop_count - p0 < 4 || expq.size() != 0) && w0 < 500) begin
            tick();
            w0++;
        end
        check("mid_reset_reached", 64'(w0 < 500), 64'd1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("mid_reset");
        echoq.delete();
        p0 = pop_count;
        rxq.push_back(8'hBC);
        repeat (20) tick();
        check("mid_reset_no_pop", 64'(pop_count - p0), 64'd0);
        check("mid_reset_no_write", mem_we, 1'b0);
        rxq.delete();
        repeat (2) tick();

`ifdef LOADER_ECHO_EN
        tx_full = 1'b1;
        q = {8'h01, 8'h5A, 8'hA5};
        model_session(q);
        foreach (q[i]) rxq.push_back(q[i]);
        w0 = wr_seen;
        pulse_start();
        repeat (10) tick();
        check("echo_held_by_tx_full", 64'(wr_seen - w0), 64'd0);
        tx_full = 1'b0;
        wait_done("echo_tx_full", 500);
        check("echo_count", 64'(wr_seen - w0), 64'd3);
        check("echo_no_timeout", error, 1'b0);
`else
        check("no_echo_wr_uart", 64'(wr_seen), 64'd0);
        check("no_echo_w_data", w_data, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width; mem_addr wraps modulo 2^ADDR_W.
REQ-002 Parameter TIMEOUT_CYC, default 24'd10_000_000, idle cycles allowed between received bytes before abort.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 rx_empty  input  1  UART receive FIFO empty; r_data valid when low.
REQ-007 r_data  input  8  head byte of the UART receive FIFO.
REQ-008 rd_uart  output  1  one-cycle pop pulse to the receive FIFO.
REQ-009 tx_full  input  1  UART transmit FIFO full.
REQ-010 w_data  output  8  byte pushed to the transmit FIFO.
REQ-011 wr_uart  output  1  one-cycle push pulse to the transmit FIFO.
REQ-012 mem_we  output  1  one-cycle program-memory write strobe.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_wdata  output  16  instruction word {high byte, low byte}.
REQ-015 busy  output  1  high from the cycle after start is accepted until DONE or ERROR.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 error  output  1  sticky timeout flag, cleared by the next accepted start or reset.

Function
REQ-018 Protocol SHALL be: byte 0 = word count N (0..255), then N words, each low byte then high byte.
REQ-019 FSM states SHALL be IDLE, GET_CNT, GET_LO, GET_HI, WRITE, ECHO, DONE, ERROR.
REQ-020 IDLE SHALL go to GET_CNT on start; start in any other state SHALL be ignored.
REQ-021 A byte SHALL be consumed in a GET_* state when rx_empty=0: r_data captured and rd_uart pulsed in that same cycle.
REQ-022 rx_empty SHALL NOT be sampled in the cycle after an rd_uart pulse, so no byte is popped twice.
REQ-023 GET_CNT SHALL go to DONE when N=0; otherwise it SHALL clear the address counter and go to GET_LO.
REQ-024 GET_HI SHALL go to WRITE; WRITE SHALL assert mem_we for exactly one cycle with mem_wdata={hi,lo} and the current address.
REQ-025 After WRITE the address SHALL increment and the remaining count SHALL decrement; at remaining=0 the FSM SHALL go to DONE, else to GET_LO.
REQ-026 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-027 The timeout counter SHALL clear on every consumed byte and on entry to GET_CNT, and SHALL increment in GET_* states while rx_empty=1.
REQ-028 When the counter reaches TIMEOUT_CYC, the FSM SHALL go to ERROR, set error, and return to IDLE next cycle without a done pulse; words already written stay written.
REQ-029 Bytes arriving while in IDLE SHALL NOT be popped.
REQ-030 Latency from the high byte popped to mem_we SHALL be exactly 1 cycle (echo disabled).

Reset
REQ-031 Reset SHALL force IDLE, and SHALL clear address, count, timeout counter, rd_uart, wr_uart, mem_we, busy, done and error to 0; mem_wdata and w_data SHALL reset to 0.
REQ-032 Reset mid-session SHALL abandon the session with no further memory writes.

Configuration
REQ-033 With LOADER_ECHO_EN defined, every consumed byte (including N) SHALL pass through ECHO before the next state.
REQ-034 In ECHO, the FSM SHALL wait while tx_full=1, then pulse wr_uart once with w_data equal to the byte; the timeout counter SHALL be frozen in ECHO.
REQ-035 With echo, the latency from the high byte popped to mem_we SHALL be 2 cycles plus any tx_full wait.
REQ-036 Without LOADER_ECHO_EN, the ECHO state SHALL be absent, wr_uart SHALL be constant 0 and w_data constant 0.

Verification
REQ-037 Bench: start, then bytes 02,34,12,CD,AB -> mem writes addr0=1234 and addr1=ABCD, one done pulse, busy low afterwards.
REQ-038 Bench: start, then byte 00 -> done pulse, no mem_we, exactly one rd_uart pulse.
REQ-039 Bench: start, then bytes 03,11,22 followed by silence for TIMEOUT_CYC cycles -> one write addr0=2211, error=1, no done; the next start clears error.
REQ-040 Bench: rx_empty held low continuously -> rd_uart never asserted in two consecutive cycles, and each byte is popped once.
REQ-041 Bench: reset asserted between the low and high bytes of word 1 -> IDLE, all outputs 0, and no write of word 1.
REQ-042 Bench with LOADER_ECHO_EN: tx_full held high for 10 cycles during an echo -> wr_uart delayed until tx_full falls, bytes echoed in order, and no timeout.
